// File: rtl/vend_timeout_scheduler_pkg.sv
// Shared timer definitions: channel state encoding, tick divider derivation and a constant clog2.
package vend_timeout_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/vend_timeout_scheduler_prescaler.sv
// Purpose: divides the board clock by DIV and emits a one-cycle tick on each wrap.
// Latency: tick is registered, high the cycle after the counter reaches DIV-1.
// Backpressure: none; when enable drops the counter snaps back to 0 so the next run starts exact.
module vend_timeout_scheduler_prescaler #(
  parameter int DIV   = 10,
  parameter int PRE_W = 4
) (
  input  logic freq_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  always_ff @(posedge freq_in) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (!enable) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/vend_timeout_scheduler.sv
// Purpose: one shared 1 Hz prescaler feeding NUM_CH seconds countdowns with start/cancel/retrigger.
// Latency: busy one cycle after start; done N*DIV cycles after a start from all-idle; rd_sec 1 cycle.
// Backpressure: none; strobes accepted every cycle with priority cancel > start > tick.
module vend_timeout_scheduler
  import vend_timeout_scheduler_pkg::*;
#(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1,
  parameter int NUM_CH  = 4,
  parameter int SEC_W   = 6
) (
  input  logic                     freq_in,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH*SEC_W-1:0]  load_sec,
  input  logic [NUM_CH-1:0]        cancel,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     tick,
  input  logic [clog2(NUM_CH)-1:0] rd_sel,
  output logic [SEC_W-1:0]         rd_sec
);
  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W = clog2(DIV);

  logic             enable;
  logic [SEC_W-1:0] cnt_arr [NUM_CH];

  // Prescaler only runs while someone needs it, so a start from all-idle sees a full first second.
  assign enable = (|busy) | (|start);

  vend_timeout_scheduler_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .freq_in (freq_in),
    .reset   (reset),
    .enable  (enable),
    .tick    (tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state;
    logic [SEC_W-1:0] cnt;
    logic [SEC_W-1:0] ld;
    logic             done_q;

    assign ld = load_sec[i*SEC_W +: SEC_W];

    always_ff @(posedge freq_in) begin
      if (reset) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (cancel[i]) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else if (start[i]) begin
          // A zero load expires immediately rather than parking in RUN with nothing to count.
          if (ld == '0) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            state <= ST_RUN;
            cnt   <= ld;
          end
        end else if (state == ST_RUN && tick) begin
          if (cnt == SEC_W'(1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - SEC_W'(1);
          end
        end
      end
    end

    assign busy[i]    = (state == ST_RUN);
    assign done[i]    = done_q;
    assign cnt_arr[i] = cnt;
  end

  always_ff @(posedge freq_in) begin
    if (reset) begin
      rd_sec <= '0;
    end else begin
      rd_sec <= cnt_arr[rd_sel];
    end
  end

endmodule

// File: tb/tb_vend_timeout_scheduler.sv
// Scoreboard bench: a deadline-based timing model predicts every cycle's outputs; a monitor compares.
module tb_vend_timeout_scheduler;
  localparam int NC   = 4;
  localparam int SW   = 6;
  localparam int SELW = 2;
  localparam int DIV  = 10;

  logic             freq_in = 1'b0;
  logic             reset;
  logic [NC-1:0]    start;
  logic [NC*SW-1:0] load_sec;
  logic [NC-1:0]    cancel;
  logic [NC-1:0]    busy;
  logic [NC-1:0]    done;
  logic             tick;
  logic [SELW-1:0]  rd_sel;
  logic [SW-1:0]    rd_sec;

  vend_timeout_scheduler #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .NUM_CH  (NC),
    .SEC_W   (SW)
  ) dut (
    .freq_in  (freq_in),
    .reset    (reset),
    .start    (start),
    .load_sec (load_sec),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .rd_sel   (rd_sel),
    .rd_sec   (rd_sec)
  );

  initial forever #5 freq_in = ~freq_in;

  typedef struct {
    int            e;
    logic [NC-1:0] busy;
    logic [NC-1:0] done;
    logic          tick;
    logic [SW-1:0] rd_sec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   e_num = 0;
  bit   mon_en = 1'b0;
  // Model: each busy channel is just the absolute edge at which it expires (0 = idle).
  int   dl[NC];
  int   anchor = 0;
  bit   anch_vld = 1'b0;
  int   last_done[NC];
  int   done_cnt[NC];

  task automatic cmp(input string nm, input int e, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, e, act, req);
    end
  endtask

  // Seconds left on a channel as seen just before edge e: ticks land on anchor + m*DIV.
  function automatic int cnt_of(input int ch, input int e);
    int nt;
    if (dl[ch] == 0) return 0;
    nt = anchor + ((e - 1 - anchor) / DIV + 1) * DIV;
    return (dl[ch] - nt) / DIV + 1;
  endfunction

  task automatic step(input logic rst, input logic [NC-1:0] st, input logic [NC*SW-1:0] ld,
                      input logic [NC-1:0] cn, input logic [SELW-1:0] rs);
    exp_t x;
    bit   en;
    int   nt;
    int   lv;
    reset    = rst;
    start    = st;
    load_sec = ld;
    cancel   = cn;
    rd_sel   = rs;
    e_num++;
    x.e = e_num; x.busy = '0; x.done = '0; x.tick = 1'b0; x.rd_sec = '0;
    if (rst) begin
      for (int c = 0; c < NC; c++) dl[c] = 0;
      anch_vld = 1'b0;
    end else begin
      x.rd_sec = SW'(cnt_of(int'(rs), e_num));
      en = (st != '0);
      for (int c = 0; c < NC; c++) if (dl[c] != 0) en = 1'b1;
      x.tick = en && anch_vld && ((e_num - anchor) % DIV == DIV - 1);
      if (!en) anch_vld = 1'b0;
      else if (!anch_vld) begin
        anchor   = e_num;
        anch_vld = 1'b1;
      end
      for (int c = 0; c < NC; c++) begin
        lv = int'(ld[c*SW +: SW]);
        if (cn[c]) dl[c] = 0;
        else if (st[c]) begin
          if (lv == 0) begin
            dl[c] = 0;
            x.done[c] = 1'b1;
          end else begin
            nt = anchor + ((e_num - anchor) / DIV + 1) * DIV;
            dl[c] = nt + (lv - 1) * DIV;
          end
        end else if (dl[c] != 0 && dl[c] == e_num) begin
          dl[c] = 0;
          x.done[c] = 1'b1;
        end
        x.busy[c] = (dl[c] != 0);
      end
    end
    exp_q.push_back(x);
    @(posedge freq_in);
    @(negedge freq_in);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, SELW'($urandom_range(0, NC - 1)));
  endtask

  task automatic go(input int ch, input int lv, input bit with_cancel);
    logic [NC-1:0]    st;
    logic [NC-1:0]    cn;
    logic [NC*SW-1:0] ld;
    st = '0; cn = '0; ld = '0;
    st[ch] = 1'b1;
    ld[ch*SW +: SW] = SW'(lv);
    if (with_cancel) cn[ch] = 1'b1;
    step(1'b0, st, ld, cn, SELW'($urandom_range(0, NC - 1)));
  endtask

  task automatic abort(input int ch);
    logic [NC-1:0] cn;
    cn = '0;
    cn[ch] = 1'b1;
    step(1'b0, '0, '0, cn, SELW'($urandom_range(0, NC - 1)));
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge freq_in);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow edge=%0d actual=empty required=entry", e_num);
        end else begin
          x = exp_q.pop_front();
          cmp("busy", x.e, int'(busy), int'(x.busy));
          cmp("done", x.e, int'(done), int'(x.done));
          cmp("tick", x.e, int'(tick), int'(x.tick));
          cmp("rd_sec", x.e, int'(rd_sec), int'(x.rd_sec));
          for (int c = 0; c < NC; c++) begin
            if (done[c]) begin
              last_done[c] = x.e;
              done_cnt[c]++;
            end
          end
        end
      end
    end
  end

  initial begin
    int s0, s1, s2, s3, r, dc;
    logic [NC-1:0]    st, cn;
    logic [NC*SW-1:0] ld;
    reset = 1'b1; start = '0; cancel = '0; load_sec = '0; rd_sel = '0;
    for (int c = 0; c < NC; c++) begin
      last_done[c] = -1000;
      done_cnt[c]  = 0;
      dl[c]        = 0;
    end
    @(negedge freq_in);
    mon_en = 1'b1;
    step(1'b1, '0, '0, '0, '0);
    step(1'b1, '0, '0, '0, '0);
    idle(3);

    // Exact first expiry from all-idle, plus a second channel joining mid-period.
    s0 = e_num + 1;
    go(0, 3, 1'b0);
    idle(12);
    s1 = e_num + 1;
    go(1, 2, 1'b0);
    idle(25);
    cmp("done0_latency", s0, last_done[0] - s0, 30);
    cmp("done0_single_pulse", s0, done_cnt[0], 1);
    cmp("done1_window", s1, int'((last_done[1] - s1 >= 11) && (last_done[1] - s1 <= 20)), 1);

    // Cancel after two ticks, then start+cancel together from idle.
    s2 = e_num + 1;
    go(2, 5, 1'b0);
    idle(19);
    abort(2);
    idle(30);
    go(2, 3, 1'b1);
    idle(3);
    cmp("cancel_no_done", s2, done_cnt[2], 0);

    // Retrigger after two ticks restarts the full count; zero load expires at once.
    s3 = e_num + 1;
    go(3, 4, 1'b0);
    idle(19);
    go(3, 4, 1'b0);
    idle(45);
    cmp("retrigger_done", s3, last_done[3] - s3, 60);
    dc = done_cnt[1];
    r = e_num + 1;
    go(1, 0, 1'b0);
    idle(2);
    cmp("zero_load_done_edge", r, last_done[1] - r, 0);
    cmp("zero_load_done_count", r, done_cnt[1] - dc, 1);

    // Simultaneous expiry, then reset mid-count and an immediate exact restart.
    st = 4'b0101; ld = '0; cn = '0;
    ld[0*SW +: SW] = SW'(2);
    ld[2*SW +: SW] = SW'(2);
    step(1'b0, st, ld, cn, '0);
    idle(25);
    cmp("same_cycle_done", e_num, last_done[0] - last_done[2], 0);
    dc = done_cnt[1];
    go(1, 5, 1'b0);
    idle(15);
    step(1'b1, '0, '0, '0, '0);
    r = e_num + 1;
    go(0, 1, 1'b0);
    idle(12);
    cmp("restart_after_reset", r, last_done[0] - r, 10);
    idle(60);
    cmp("reset_drops_done", r, done_cnt[1] - dc, 0);

    // Readback sweep while ch1 counts down.
    go(1, 3, 1'b0);
    for (int k = 0; k < 35; k++) step(1'b0, '0, '0, '0, SELW'(k % NC));

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      st = '0; cn = '0; ld = '0;
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 29) == 0) st[c] = 1'b1;
        if ($urandom_range(0, 49) == 0) cn[c] = 1'b1;
        ld[c*SW +: SW] = SW'($urandom_range(0, 5));
      end
      step(($urandom_range(0, 399) == 0), st, ld, cn, SELW'($urandom_range(0, NC - 1)));
    end

    mon_en = 1'b0;
    cmp("scoreboard_drained", e_num, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
